// File: rtl/voice_pkg.sv
// Shared types and constants for the per-sample voice scheduler.
package voice_pkg;

    localparam int NUM_VOICES_DEF = 3;
    localparam int WAVE_W_DEF     = 12;
    localparam int ENV_W          = 8;
    localparam int ENV_SHIFT      = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENV_START,
        S_WAIT_MREQ,
        S_MUL_ISSUE,
        S_MUL_WAIT,
        S_WAIT_ENV,
        S_OUT
    } sched_state_e;

endpackage

// File: rtl/voice_scheduler.sv
// Per-sample sequencer: walks each voice through the envelope block and the shared
// multiplier, accumulates the envelope-scaled samples and publishes one mix per tick.
module voice_scheduler
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int WAVE_W     = WAVE_W_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         sample_tick_i,
    input  logic [NUM_VOICES-1:0]        voice_en_i,
    input  logic [NUM_VOICES*WAVE_W-1:0] wave_i,
    output logic [1:0]                   voice_idx_o,
    output logic                         env_start_o,
    input  logic                         env_mult_start_i,
    input  logic [ENV_W-1:0]             env_raw_i,
    output logic                         env_mult_ready_o,
    input  logic                         env_ready_i,
    output logic                         mul_start_o,
    output logic [WAVE_W-1:0]            mul_a_o,
    output logic [ENV_W-1:0]             mul_b_o,
    input  logic                         mul_done_i,
    input  logic [WAVE_W+ENV_W-1:0]      mul_p_i,
    output logic [WAVE_W+1:0]            mix_o,
    output logic                         mix_valid_o,
    output logic                         overrun_o,
    output logic                         busy_o
);

    localparam int ACC_W = WAVE_W + 2;

    sched_state_e            state_q;
    logic [1:0]              voice_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] mix_q;
    logic                    mix_valid_q;
    logic                    env_start_q;
    logic                    mul_start_q;
    logic [WAVE_W-1:0]       mul_a_q;
    logic [ENV_W-1:0]        mul_b_q;
    logic                    overrun_q;

    logic [WAVE_W-1:0]       wave_sel;
    logic                    en_sel;
    logic signed [ACC_W-1:0] term;
    logic                    last_voice;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        wave_sel = '0;
        en_sel   = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_q == 2'(v)) begin
                wave_sel = wave_i[v*WAVE_W +: WAVE_W];
                en_sel   = voice_en_i[v];
            end
        end
    end

    // Arithmetic shift floors toward -inf; the result always fits in the accumulator.
    assign term       = ACC_W'($signed(mul_p_i) >>> ENV_SHIFT);
    assign acc_d      = acc_q + (en_sel ? term : '0);
    assign last_voice = (voice_q == 2'(NUM_VOICES - 1));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            voice_q     <= '0;
            acc_q       <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            env_start_q <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            env_start_q <= 1'b0;
            mul_start_q <= 1'b0;
            mix_valid_q <= 1'b0;

            if (sample_tick_i && state_q != S_IDLE) begin
                overrun_q <= 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (sample_tick_i) begin
                        acc_q       <= '0;
                        voice_q     <= '0;
                        env_start_q <= 1'b1;
                        state_q     <= S_ENV_START;
                    end
                end
                S_ENV_START: state_q <= S_WAIT_MREQ;
                S_WAIT_MREQ: begin
                    if (env_mult_start_i) begin
                        mul_a_q     <= wave_sel;
                        mul_b_q     <= env_raw_i;
                        mul_start_q <= 1'b1;
                        state_q     <= S_MUL_ISSUE;
                    end
                end
                S_MUL_ISSUE: state_q <= S_MUL_WAIT;
                S_MUL_WAIT: begin
                    if (mul_done_i) begin
                        acc_q   <= acc_d;
                        state_q <= S_WAIT_ENV;
                    end
                end
                S_WAIT_ENV: begin
                    if (env_ready_i) begin
                        if (last_voice) begin
                            mix_q       <= acc_q;
                            mix_valid_q <= 1'b1;
                            state_q     <= S_OUT;
                        end else begin
                            voice_q     <= voice_q + 2'd1;
                            env_start_q <= 1'b1;
                            state_q     <= S_ENV_START;
                        end
                    end
                end
                S_OUT:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign voice_idx_o      = voice_q;
    assign env_start_o      = env_start_q;
    assign env_mult_ready_o = (state_q == S_MUL_WAIT) && mul_done_i;
    assign mul_start_o      = mul_start_q;
    assign mul_a_o          = mul_a_q;
    assign mul_b_o          = mul_b_q;
    assign mix_o            = mix_q;
    assign mix_valid_o      = mix_valid_q;
    assign overrun_o        = overrun_q;
    assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with behavioural envelope and multiplier models.
module tb_voice_scheduler;

    localparam int NV = 3;
    localparam int WW = 12;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            sample_tick_i = 1'b0;
    logic [NV-1:0]   voice_en_i = '0;
    logic [NV*WW-1:0] wave_i = '0;
    logic [1:0]      voice_idx_o;
    logic            env_start_o;
    logic            env_mult_start_i = 1'b0;
    logic [7:0]      env_raw_i = '0;
    logic            env_mult_ready_o;
    logic            env_ready_i = 1'b0;
    logic            mul_start_o;
    logic [WW-1:0]   mul_a_o;
    logic [7:0]      mul_b_o;
    logic            mul_done_i = 1'b0;
    logic [WW+7:0]   mul_p_i = '0;
    logic [WW+1:0]   mix_o;
    logic            mix_valid_o;
    logic            overrun_o;
    logic            busy_o;

    voice_scheduler #(.NUM_VOICES(NV), .WAVE_W(WW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .sample_tick_i(sample_tick_i),
        .voice_en_i(voice_en_i), .wave_i(wave_i), .voice_idx_o(voice_idx_o),
        .env_start_o(env_start_o), .env_mult_start_i(env_mult_start_i),
        .env_raw_i(env_raw_i), .env_mult_ready_o(env_mult_ready_o),
        .env_ready_i(env_ready_i), .mul_start_o(mul_start_o), .mul_a_o(mul_a_o),
        .mul_b_o(mul_b_o), .mul_done_i(mul_done_i), .mul_p_i(mul_p_i),
        .mix_o(mix_o), .mix_valid_o(mix_valid_o), .overrun_o(overrun_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural envelope + multiplier, all activity on the falling edge.
    int          mul_lat = 1;
    int          mul_cnt = 0;
    logic        env_start_seen = 1'b0;
    logic        mready_seen = 1'b0;
    logic [WW-1:0] sa;
    logic [7:0]  sb;
    int          n_env_start = 0, n_mready = 0, n_mul_start = 0, n_stable_err = 0, n_valid = 0;
    logic [5:0]  idx_seq = '0;
    logic signed [WW+1:0] last_mix = '0;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            mul_cnt = 0; env_start_seen = 1'b0; mready_seen = 1'b0;
            env_mult_start_i = 1'b0; env_ready_i = 1'b0; mul_done_i = 1'b0;
        end else begin
            env_mult_start_i = env_start_seen;
            env_start_seen   = env_start_o;
            if (env_start_o) begin
                n_env_start++;
                idx_seq = {idx_seq[3:0], voice_idx_o};
            end
            env_ready_i = mready_seen;
            mready_seen = 1'b0;
            mul_done_i  = 1'b0;
            if (mul_cnt > 0) begin
                if (mul_a_o != sa || mul_b_o != sb) n_stable_err++;
                mul_cnt--;
                if (mul_cnt == 0) begin
                    mul_done_i = 1'b1;
                    mul_p_i = 20'($signed(mul_a_o) * $signed({1'b0, mul_b_o}));
                end
            end
            if (mul_start_o) begin
                n_mul_start++;
                mul_cnt = mul_lat;
                sa = mul_a_o;
                sb = mul_b_o;
            end
            if (mix_valid_o) begin
                n_valid++;
                last_mix = mix_o;
            end
            #1;
            if (env_mult_ready_o) begin
                mready_seen = 1'b1;
                n_mready++;
            end
        end
    end

    typedef struct {
        logic [NV*WW-1:0] wave;
        logic [7:0]       env;
        logic [NV-1:0]    en;
        int               lat;
        int               exp_mix;
        int               exp_cyc;
    } vec_t;

    vec_t vecs[6];

    // Pulses a tick, then watches `budget` cycles; extra_at injects a second tick.
    task automatic run_frame(input int budget, input int extra_at, output int lat);
        @(negedge clk_i);
        #3;
        n_env_start = 0; n_mready = 0; n_mul_start = 0; n_stable_err = 0; n_valid = 0;
        idx_seq = '0;
        sample_tick_i = 1'b1;
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk_i);
            sample_tick_i = (n == extra_at);
            #2;
            if (mix_valid_o && lat < 0) lat = n;
        end
        sample_tick_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        int lat;
        vecs[0] = '{{12'h7FF, 12'h7FF, 12'h7FF}, 8'hFF, 3'b111, 1, 6117, 16};
        vecs[1] = '{{12'h800, 12'h800, 12'h800}, 8'hFF, 3'b111, 1, -6120, 16};
        vecs[2] = '{{12'h7FF, 12'h7FF, 12'h7FF}, 8'h80, 3'b010, 1, 1023, 16};
        vecs[3] = '{{12'h7FF, 12'h7FF, 12'h7FF}, 8'hFF, 3'b111, 5, 6117, 28};
        vecs[4] = '{{12'd1024, 12'hFFF, 12'd100}, 8'h10, 3'b101, 2, 70, 19};
        vecs[5] = '{{12'hFFF, 12'hFFF, 12'hFFF}, 8'h01, 3'b111, 1, -3, 16};

        #12;
        check("rst_busy", busy_o, 0);
        check("rst_mix", mix_o, 0);
        check("rst_valid", mix_valid_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_voice_idx", voice_idx_o, 0);
        check("rst_env_start", env_start_o, 0);
        check("rst_mul_start", mul_start_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 6; i++) begin
            wave_i = vecs[i].wave;
            env_raw_i = vecs[i].env;
            voice_en_i = vecs[i].en;
            mul_lat = vecs[i].lat;
            run_frame(vecs[i].exp_cyc + 8, 0, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_cyc);
            check($sformatf("v%0d_mix", i), longint'(last_mix), vecs[i].exp_mix);
            check($sformatf("v%0d_valid_cnt", i), n_valid, 1);
            check($sformatf("v%0d_env_starts", i), n_env_start, NV);
            check($sformatf("v%0d_mult_ready", i), n_mready, NV);
            check($sformatf("v%0d_mul_starts", i), n_mul_start, NV);
            check($sformatf("v%0d_voice_seq", i), idx_seq, 6'b00_01_10);
            check($sformatf("v%0d_operand_hold", i), n_stable_err, 0);
            check($sformatf("v%0d_idle_busy", i), busy_o, 0);
            check($sformatf("v%0d_no_overrun", i), overrun_o, 0);
        end

        // Second tick mid-frame is ignored but flagged, and the flag is sticky.
        wave_i = {12'h7FF, 12'h7FF, 12'h7FF}; env_raw_i = 8'hFF; voice_en_i = 3'b111; mul_lat = 1;
        run_frame(30, 7, lat);
        check("ovr_valid_cnt", n_valid, 1);
        check("ovr_latency", lat, 16);
        check("ovr_mix", longint'(last_mix), 6117);
        check("ovr_flag", overrun_o, 1);
        run_frame(24, 0, lat);
        check("ovr_sticky", overrun_o, 1);
        check("ovr_next_mix", longint'(last_mix), 6117);
        do_reset();
        #1;
        check("ovr_cleared", overrun_o, 0);

        // Tick coinciding with the OUT cycle counts as overrun and starts nothing.
        run_frame(30, 16, lat);
        check("out_tick_valid_cnt", n_valid, 1);
        check("out_tick_overrun", overrun_o, 1);
        check("out_tick_idle", busy_o, 0);
        check("out_tick_env_starts", n_env_start, NV);
        do_reset();

        // Reset during voice 1 MUL_WAIT abandons the frame.
        mul_lat = 5;
        env_raw_i = 8'h80;
        @(negedge clk_i);
        #3;
        n_mul_start = 0; n_valid = 0;
        sample_tick_i = 1'b1;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk_i);
            sample_tick_i = 1'b0;
            #2;
            if (voice_idx_o == 2'd1 && mul_start_o) begin
                lat = n;
                break;
            end
        end
        check("mrst_reached_v1", lat > 0, 1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("mrst_mix", mix_o, 0);
        check("mrst_busy", busy_o, 0);
        check("mrst_voice_idx", voice_idx_o, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        n_valid = 0;
        repeat (30) @(negedge clk_i);
        check("mrst_no_valid", n_valid, 0);
        mul_lat = 1;
        run_frame(24, 0, lat);
        check("mrst_restart_seq", idx_seq, 6'b00_01_10);
        check("mrst_restart_latency", lat, 16);
        check("mrst_restart_mix", longint'(last_mix), 3069);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Per-sample sequencer for the voice datapath.
- On each sample tick it walks voices 0..NUM_VOICES-1 through the shared envelope generator. For each voice it services the envelope's multiply request on the shared sequential multiplier (waveform sample × 8-bit envelope level), accumulates the scaled products and publishes one mixed sample per tick.
- It sits between the sample-rate timer, the voice register file (selected via voice_idx_o), the envelope block and the multiplier.

Parameters:
- NUM_VOICES, 3, number of voices sequenced per tick (voice_idx_o is 2 bits, so ≤4).
- WAVE_W, 12, signed waveform sample width.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- sample_tick_i  in  1  one-cycle pulse, start of a sample frame
- voice_en_i  in  NUM_VOICES  per-voice mix enable
- wave_i  in  NUM_VOICES*WAVE_W  signed waveform samples, voice v at [v*WAVE_W +: WAVE_W]
- voice_idx_o  out  2  voice currently serviced (drives envelope voice_idx_i and register-file select)
- env_start_o  out  1  start pulse to envelope
- env_mult_start_i  in  1  envelope multiply request
- env_raw_i  in  8  envelope level, unsigned
- env_mult_ready_o  out  1  multiply complete, to envelope
- env_ready_i  in  1  envelope done for this voice
- mul_start_o  out  1  multiplier start pulse
- mul_a_o  out  WAVE_W  signed operand (waveform)
- mul_b_o  out  8  unsigned operand (envelope)
- mul_done_i  in  1  multiplier result valid, one-cycle pulse
- mul_p_i  in  WAVE_W+8  signed product
- mix_o  out  WAVE_W+2  signed mixed sample
- mix_valid_o  out  1  one-cycle pulse, mix_o updated
- overrun_o  out  1  sticky: tick arrived while busy
- busy_o  out  1  frame in progress

Behaviour:
- Reset (async, rst_ni low): FSM to IDLE; voice_idx_o=0; accumulator=0; mix_o=0; all pulses, overrun_o and busy_o are 0. Reset mid-frame abandons the frame with no mix_valid_o.
- FSM states: IDLE, ENV_START, WAIT_MREQ, MUL_WAIT, WAIT_ENV, OUT. A MUL_ISSUE state sits between WAIT_MREQ and MUL_WAIT.
- IDLE: on sample_tick_i, clear accumulator, set voice_idx_o=0 and go to ENV_START.
- ENV_START: env_start_o=1 for exactly one cycle, then WAIT_MREQ.
- WAIT_MREQ: on env_mult_start_i, latch wave_i[voice] and env_raw_i into mul_a_o/mul_b_o, then go to MUL_ISSUE.
- MUL_ISSUE: mul_start_o=1 for one cycle; operands are held stable until mul_done_i. Then MUL_WAIT.
- MUL_WAIT: on mul_done_i:
  - env_mult_ready_o=1 combinationally in that same cycle (only then).
  - If voice_en_i[voice] is set, add (mul_p_i >>> 8) to the accumulator. The shift is arithmetic, floor toward -inf. Otherwise add 0.
  - Go to WAIT_ENV.
- Disabled voices still run the envelope handshake, so envelope timing is unaffected.
- WAIT_ENV: on env_ready_i, if voice==NUM_VOICES-1 go to OUT; otherwise voice_idx_o++ and go to ENV_START.
- OUT: register accumulator into mix_o, mix_valid_o=1 for one cycle, then IDLE.
- Accumulator width is WAVE_W+2. The sum cannot overflow for NUM_VOICES≤4, so no saturation.
- Latency: with multiplier done L≥1 cycles after mul_start_o, a tick sampled at cycle t gives mix_valid_o at t+1+NUM_VOICES*(4+L). For L=1 and 3 voices that is t+16.
- sample_tick_i outside IDLE: ignored and overrun_o set. overrun_o clears only on reset. A tick in the same cycle as OUT also counts as overrun.
- busy_o=1 in every state except IDLE.
- voice_idx_o and the wave select are stable from ENV_START through WAIT_ENV of each voice.
- Unexpected env_mult_start_i, mul_done_i or env_ready_i outside their wait states are ignored.

Decomposition:
- Shared package voice_pkg:
  - sched_state_e enum.
  - NUM_VOICES_DEF=3, WAVE_W_DEF=12.
  - ENV_W=8 and ENV_SHIFT=8 constants.
- Single module; no sub-module. The accumulator is inline (~150–250 lines RTL).

Test Plan:
- Bench setup: envelope and multiplier driven by behavioural models; multiplier L=1 unless stated.
- All voices wave=0x7FF, env_raw=0xFF, en=3'b111; one tick at cycle t -> mix_valid_o pulse at t+16, mix_o=6117 (3×2039).
- Waves {0x800,0x800,0x800} (−2048), env=0xFF -> mix_o=−6120.
- voice_en_i=3'b010, waves 0x7FF, env=0x80 -> all 3 env_start_o pulses still occur, mix_o=1023 (2047×128>>>8).
- Multiplier L=5 -> mix_valid_o at t+1+3×9=t+28; mul_a_o/mul_b_o stable throughout each MUL_WAIT.
- Second tick during frame -> ignored (only one mix_valid_o), overrun_o=1 and remains set until rst_ni low.
- rst_ni low during voice 1 MUL_WAIT -> immediate mix_o=0, busy_o=0, no mix_valid_o; the next tick starts cleanly at voice_idx_o=0.
